fe_trace_capture_ctrl: RTL and testbench

Capture sequencer for the ARM trace front end. It arms capture, waits for a trigger, and runs an inter-event timestamp counter. It converts front-end events into FIFO write commands: short-time DATA/STAT entries, plus a long TIME entry whenever the gap exceeds the short-timestamp range. It enforces capture length and FIFO-full limits and drives `I_fifo_wr`, `I_fifo_command` and `I_fifo_time` of the trace front end.

---
 rtl/fe_trace_capture_ctrl_pkg.sv | 15 +
 rtl/fe_trace_capture_ctrl_ts_counter.sv | 33 +++
 rtl/fe_trace_capture_ctrl.sv | 167 ++++++++++++++++
 tb/tb_fe_trace_capture_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fe_trace_capture_ctrl_pkg.sv
// Shared state encoding and FIFO command codes for the trace capture sequencer.
package fe_trace_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } cap_state_e;

  localparam logic [1:0] CmdData = 2'b00;
  localparam logic [1:0] CmdTime = 2'b01;
  localparam logic [1:0] CmdStat = 2'b10;

endpackage

// File: rtl/fe_trace_capture_ctrl_ts_counter.sv
// Inter-event timestamp counter: saturating increment, reload to 1, clear to 0,
// with an all-ones flag used to trigger idle rollover entries.
module fe_trace_capture_ctrl_ts_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             trace_clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             reload_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o,
  output logic             all_ones_o
);

  logic [Width-1:0] count_q;

  assign count_o    = count_q;
  assign all_ones_o = &count_q;

  // Clear beats reload beats increment; increment holds at all-ones.
  always_ff @(posedge trace_clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (reload_i) begin
      count_q <= Width'(1);
    end else if (inc_i && !all_ones_o) begin
      count_q <= count_q + Width'(1);
    end
  end

endmodule

// File: rtl/fe_trace_capture_ctrl.sv
// Trace capture sequencer: arm, wait for trigger, then turn front-end events into
// FIFO write commands with short or long (TIME + event) timestamps.
module fe_trace_capture_ctrl
  import fe_trace_capture_ctrl_pkg::*;
#(
  parameter int unsigned pTIMESTAMP_FULL_WIDTH = 16,
  parameter int unsigned pCAPTURE_LEN_WIDTH    = 16
) (
  input  logic                             trace_clk,
  input  logic                             reset,
  input  logic                             I_arm,
  input  logic                             I_stop,
  input  logic                             I_trigger,
  input  logic                             I_event,
  input  logic [1:0]                       I_data_cmd,
  input  logic [15:0]                      I_max_short_timestamp,
  input  logic [pCAPTURE_LEN_WIDTH-1:0]    I_capture_len,
  input  logic                             I_fifo_full,
  output logic                             O_fifo_wr,
  output logic [1:0]                       O_fifo_command,
  output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fifo_time,
  output logic [1:0]                       O_state,
  output logic                             O_done,
  output logic                             O_overflow,
  output logic [pCAPTURE_LEN_WIDTH-1:0]    O_entry_count
);

  localparam int unsigned TsW  = pTIMESTAMP_FULL_WIDTH;
  localparam int unsigned ClW  = pCAPTURE_LEN_WIDTH;
  localparam int unsigned CmpW = (TsW > 16) ? TsW : 16;

  cap_state_e       state_q;
  logic             pend_q;
  logic [1:0]       pend_cmd_q;
  logic             wr_q;
  logic [1:0]       cmd_q;
  logic [TsW-1:0]   time_q;
  logic             ovf_q;
  logic [ClW-1:0]   count_q;

  logic [TsW-1:0]   ts;
  logic             ts_max;
  logic             in_cap, arm_ok, ts_clear, ts_reload, ts_inc;
  logic             wr_req, evt_take, evt_drop, rollover, pend_set, is_short, cap_hit;
  logic [1:0]       wr_cmd;
  logic [TsW-1:0]   wr_time;
  logic [ClW-1:0]   count_inc;

  fe_trace_capture_ctrl_ts_counter #(
    .Width (TsW)
  ) u_ts_counter (
    .trace_clk  (trace_clk),
    .reset      (reset),
    .clear_i    (ts_clear),
    .reload_i   (ts_reload),
    .inc_i      (ts_inc),
    .count_o    (ts),
    .all_ones_o (ts_max)
  );

  assign in_cap    = (state_q == StCapture) && !I_stop;
  assign arm_ok    = !I_stop && I_arm && ((state_q == StIdle) || (state_q == StDone));
  assign ts_clear  = arm_ok || (!I_stop && (state_q == StArmed) && I_trigger);
  assign ts_reload = evt_take || rollover;
  assign ts_inc    = in_cap && !ts_reload;
  assign is_short  = CmpW'(ts) <= CmpW'(I_max_short_timestamp);
  assign count_inc = count_q + ClW'(1);
  assign cap_hit   = (I_capture_len != '0) && (count_inc == I_capture_len);

  // Pick this cycle's write: pending second half first, then a new event, then rollover.
  always_comb begin
    wr_req   = 1'b0;
    wr_cmd   = CmdData;
    wr_time  = '0;
    evt_take = 1'b0;
    evt_drop = 1'b0;
    rollover = 1'b0;
    pend_set = 1'b0;
    if (in_cap) begin
      if (pend_q) begin
        // Event half of a long pair goes out now; a colliding event is lost.
        wr_req   = 1'b1;
        wr_cmd   = pend_cmd_q;
        evt_drop = I_event;
      end else if (I_event) begin
        evt_take = 1'b1;
        wr_req   = 1'b1;
        wr_time  = ts;
        if (is_short) begin
          wr_cmd = I_data_cmd;
        end else begin
          wr_cmd   = CmdTime;
          pend_set = 1'b1;
        end
      end else if (ts_max) begin
        rollover = 1'b1;
        wr_req   = 1'b1;
        wr_cmd   = CmdTime;
        wr_time  = ts;
      end
    end
  end

  // Capture FSM with registered FIFO strobe, status and counters.
  always_ff @(posedge trace_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pend_q     <= 1'b0;
      pend_cmd_q <= CmdData;
      wr_q       <= 1'b0;
      cmd_q      <= CmdData;
      time_q     <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      wr_q <= 1'b0;
      if (I_stop) begin
        state_q <= StIdle;
        pend_q  <= 1'b0;
      end else begin
        case (state_q)
          StIdle, StDone: begin
            if (I_arm) begin
              state_q <= StArmed;
              ovf_q   <= 1'b0;
              count_q <= '0;
            end
          end
          StArmed: begin
            if (I_trigger) state_q <= StCapture;
          end
          StCapture: begin
            if (evt_drop) ovf_q <= 1'b1;
            pend_q <= pend_set;
            if (pend_set) pend_cmd_q <= I_data_cmd;
            if (wr_req) begin
              if (I_fifo_full) begin
                ovf_q   <= 1'b1;
                state_q <= StDone;
                pend_q  <= 1'b0;
              end else begin
                wr_q    <= 1'b1;
                cmd_q   <= wr_cmd;
                time_q  <= wr_time;
                count_q <= count_inc;
                if (cap_hit) begin
                  state_q <= StDone;
                  pend_q  <= 1'b0;
                end
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign O_fifo_wr      = wr_q;
  assign O_fifo_command = cmd_q;
  assign O_fifo_time    = time_q;
  assign O_state        = state_q;
  assign O_done         = (state_q == StDone);
  assign O_overflow     = ovf_q;
  assign O_entry_count  = count_q;

endmodule

// File: tb/tb_fe_trace_capture_ctrl.sv
// Bench for fe_trace_capture_ctrl: directed stimulus, a timeline-based reference
// model checked every cycle, and literal checks on key entries.
module tb_fe_trace_capture_ctrl;

  logic        trace_clk = 1'b0;
  logic        reset = 1'b1;
  logic        I_arm = 1'b0, I_stop = 1'b0, I_trigger = 1'b0, I_event = 1'b0;
  logic [1:0]  I_data_cmd = 2'b00;
  logic [15:0] I_max_short_timestamp = 16'd255;
  logic [15:0] I_capture_len = 16'd0;
  logic        I_fifo_full = 1'b0;
  logic        O_fifo_wr;
  logic [1:0]  O_fifo_command;
  logic [15:0] O_fifo_time;
  logic [1:0]  O_state;
  logic        O_done;
  logic        O_overflow;
  logic [15:0] O_entry_count;

  fe_trace_capture_ctrl #(
    .pTIMESTAMP_FULL_WIDTH (16),
    .pCAPTURE_LEN_WIDTH    (16)
  ) dut (
    .trace_clk             (trace_clk),
    .reset                 (reset),
    .I_arm                 (I_arm),
    .I_stop                (I_stop),
    .I_trigger             (I_trigger),
    .I_event               (I_event),
    .I_data_cmd            (I_data_cmd),
    .I_max_short_timestamp (I_max_short_timestamp),
    .I_capture_len         (I_capture_len),
    .I_fifo_full           (I_fifo_full),
    .O_fifo_wr             (O_fifo_wr),
    .O_fifo_command        (O_fifo_command),
    .O_fifo_time           (O_fifo_time),
    .O_state               (O_state),
    .O_done                (O_done),
    .O_overflow            (O_overflow),
    .O_entry_count         (O_entry_count)
  );

  always #5 trace_clk = ~trace_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Timestamp is derived from the cycle where it was last zero ("base"):
  // after a trigger in cycle t it reads 0 in cycle t+1; after an event or
  // rollover in cycle e it reads 1 in cycle e+1.
  typedef struct packed {logic [1:0] cmd; logic [15:0] tm;} ent_t;

  longint cyc = 0;
  longint base = 0;
  int     mstate = 0;
  bit     m_live = 1'b0;
  bit     m_ovf = 1'b0;
  int     m_count = 0;
  bit     exp_wr = 1'b0;
  ent_t   exp_ent = '0;
  ent_t   later[$];
  ent_t   wlog[$];

  always @(posedge trace_clk) begin
    longint ts;
    bit     have;
    ent_t   e;
    exp_wr = 1'b0;
    if (reset) begin
      m_live = 1'b1; mstate = 0; m_ovf = 1'b0; m_count = 0; exp_ent = '0; later.delete();
    end else if (I_stop) begin
      mstate = 0; later.delete();
    end else if (mstate == 0 || mstate == 3) begin
      if (I_arm) begin mstate = 1; m_ovf = 1'b0; m_count = 0; end
    end else if (mstate == 1) begin
      if (I_trigger) begin mstate = 2; base = cyc + 1; end
    end else begin
      ts = cyc - base;
      if (ts > 65535) ts = 65535;
      have = 1'b0;
      e = '0;
      if (later.size() > 0) begin
        e = later.pop_front(); have = 1'b1;
        if (I_event) m_ovf = 1'b1;
      end else if (I_event) begin
        have = 1'b1; base = cyc;
        if (ts <= longint'(I_max_short_timestamp)) e = '{I_data_cmd, 16'(ts)};
        else begin
          e = '{2'b01, 16'(ts)};
          later.push_back('{I_data_cmd, 16'd0});
        end
      end else if (ts == 65535) begin
        have = 1'b1; base = cyc; e = '{2'b01, 16'hFFFF};
      end
      if (have) begin
        if (I_fifo_full) begin
          m_ovf = 1'b1; mstate = 3; later.delete();
        end else begin
          exp_wr = 1'b1; exp_ent = e; m_count++;
          if (I_capture_len != 0 && m_count == int'(I_capture_len)) begin
            mstate = 3; later.delete();
          end
        end
      end
    end
    cyc++;
  end

  // Per-cycle comparison against the model, plus a log of observed writes.
  always @(negedge trace_clk) begin
    if (m_live) begin
      chk("wr", 32'(O_fifo_wr), 32'(exp_wr));
      if (exp_wr) begin
        chk("cmd", 32'(O_fifo_command), 32'(exp_ent.cmd));
        chk("time", 32'(O_fifo_time), 32'(exp_ent.tm));
      end
      chk("state", 32'(O_state), 32'(mstate));
      chk("done", 32'(O_done), 32'(mstate == 3));
      chk("overflow", 32'(O_overflow), 32'(m_ovf));
      chk("entry_count", 32'(O_entry_count), 32'(m_count[15:0]));
      if (O_fifo_wr === 1'b1) wlog.push_back('{O_fifo_command, O_fifo_time});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge trace_clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_arm();
    I_arm = 1'b1; tick(); I_arm = 1'b0;
  endtask

  task automatic pulse_trigger();
    I_trigger = 1'b1; tick(); I_trigger = 1'b0;
  endtask

  task automatic pulse_stop();
    I_stop = 1'b1; tick(); I_stop = 1'b0;
  endtask

  task automatic pulse_event(input logic [1:0] cmd);
    I_event = 1'b1; I_data_cmd = cmd; tick(); I_event = 1'b0;
  endtask

  initial begin
    int waited;
    int n0;
    step(2);
    reset = 1'b0;
    chk("reset_state", 32'(O_state), 32'd0);
    chk("reset_wr", 32'(O_fifo_wr), 32'd0);
    chk("reset_count", 32'(O_entry_count), 32'd0);
    tick();

    // Short STAT entry: event in the 11th cycle after the trigger, ts = 10.
    pulse_arm();
    chk("armed_state", 32'(O_state), 32'd1);
    pulse_trigger();
    chk("capture_state", 32'(O_state), 32'd2);
    step(10);
    pulse_event(2'b10);
    chk("short_wr", 32'(O_fifo_wr), 32'd1);
    chk("short_cmd", 32'(O_fifo_command), 32'd2);
    chk("short_time", 32'(O_fifo_time), 32'd10);

    // Long pair: 300 cycles after the previous event, max short 255.
    step(299);
    pulse_event(2'b00);
    chk("long_time_cmd", 32'(O_fifo_command), 32'd1);
    chk("long_time_val", 32'(O_fifo_time), 32'd300);
    tick();
    chk("long_evt_wr", 32'(O_fifo_wr), 32'd1);
    chk("long_evt_cmd", 32'(O_fifo_command), 32'd0);
    chk("long_evt_time", 32'(O_fifo_time), 32'd0);
    chk("long_count", 32'(O_entry_count), 32'd3);

    // Idle rollover after 65535 quiet cycles, then an event 5 cycles later.
    pulse_stop();
    pulse_arm();
    pulse_trigger();
    waited = 0;
    while (O_fifo_wr !== 1'b1 && waited < 70000) begin
      tick();
      waited++;
    end
    chk("rollover_wait", 32'(waited), 32'd65536);
    chk("rollover_cmd", 32'(O_fifo_command), 32'd1);
    chk("rollover_time", 32'(O_fifo_time), 32'hFFFF);
    step(4);
    pulse_event(2'b00);
    chk("after_roll_wr", 32'(O_fifo_wr), 32'd1);
    chk("after_roll_time", 32'(O_fifo_time), 32'd5);

    // Capture length 3 with five events.
    pulse_stop();
    I_capture_len = 16'd3;
    pulse_arm();
    pulse_trigger();
    step(3);
    n0 = wlog.size();
    for (int i = 0; i < 5; i++) begin
      pulse_event(2'b00);
      step(2);
    end
    chk("caplen_writes", 32'(wlog.size() - n0), 32'd3);
    chk("caplen_count", 32'(O_entry_count), 32'd3);
    chk("caplen_state", 32'(O_state), 32'd3);
    chk("caplen_done", 32'(O_done), 32'd1);

    // FIFO full on an event, then re-arm from DONE.
    I_capture_len = 16'd0;
    pulse_arm();
    chk("rearm_count", 32'(O_entry_count), 32'd0);
    pulse_trigger();
    step(3);
    I_fifo_full = 1'b1;
    pulse_event(2'b10);
    I_fifo_full = 1'b0;
    chk("full_wr", 32'(O_fifo_wr), 32'd0);
    chk("full_ovf", 32'(O_overflow), 32'd1);
    chk("full_state", 32'(O_state), 32'd3);
    pulse_arm();
    chk("arm_clr_ovf", 32'(O_overflow), 32'd0);
    chk("arm_state", 32'(O_state), 32'd1);

    // Stop between the TIME and event halves.
    pulse_trigger();
    step(300);
    pulse_event(2'b10);
    chk("stop_time_half", 32'(O_fifo_command), 32'd1);
    pulse_stop();
    chk("stop_wr", 32'(O_fifo_wr), 32'd0);
    chk("stop_state", 32'(O_state), 32'd0);
    tick();
    chk("stop_wr2", 32'(O_fifo_wr), 32'd0);

    // Reset between the halves.
    pulse_arm();
    pulse_trigger();
    step(300);
    pulse_event(2'b00);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_wr", 32'(O_fifo_wr), 32'd0);
    chk("rst_state", 32'(O_state), 32'd0);
    chk("rst_count", 32'(O_entry_count), 32'd0);
    tick();
    chk("rst_wr2", 32'(O_fifo_wr), 32'd0);

    // Event colliding with the pending half is dropped and flags overflow.
    pulse_arm();
    pulse_trigger();
    step(300);
    pulse_event(2'b00);
    pulse_event(2'b10);
    chk("drop_wr", 32'(O_fifo_wr), 32'd1);
    chk("drop_cmd", 32'(O_fifo_command), 32'd0);
    chk("drop_ovf", 32'(O_overflow), 32'd1);
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
